myo_sweep_scheduler: RTL and testbench

Parametrised successor to the single-bus MYO motor scheduler. It sequences SPI frames across up to 254 motors on one bus, with these additions:
- per-motor enable mask, so disabled motors are skipped;
- fixed-period sweeps with overrun detection;
- a per-frame watchdog timeout;
- measured sweep period.

It sits between the Avalon register file and the SpiControl/spi_master pair. It drives per-motor data latch strobes and one-hot PID update pulses.

---
 rtl/myo_sweep_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_myo_sweep_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/myo_sweep_scheduler.sv
// myo_sweep_scheduler: sequences SPI frames across the enabled motors of one bus,
// with optional fixed sweep period, overrun flag, per-frame watchdog and
// measured sweep period. Sits between the register file and SpiControl.
module myo_sweep_scheduler #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int CLOCK_SPEED_HZ   = 50_000_000,
  parameter int TIMEOUT_CYCLES   = 5000,
  parameter int PERIOD_WIDTH     = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
  input  logic [PERIOD_WIDTH-1:0]     period_cycles,
  input  logic                        clear_status,
  input  logic                        spi_done,
  input  logic                        ss_n,
  output logic                        spi_start,
  output logic [7:0]                  motor,
  output logic [NUMBER_OF_MOTORS-1:0] ss_n_o,
  output logic                        latch_valid,
  output logic [7:0]                  latch_motor,
  output logic [NUMBER_OF_MOTORS-1:0] pid_update,
  output logic [PERIOD_WIDTH-1:0]     cycle_count,
  output logic                        overrun,
  output logic [15:0]                 timeout_count,
  output logic [7:0]                  timeout_motor,
  output logic                        busy
);

  // Watchdog only has to hold 0..TIMEOUT_CYCLES-1. The clock rate carries no
  // logic; a negative value would merely widen the watchdog by one bit.
  localparam int WD_W = ((TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1)
                        + ((CLOCK_SPEED_HZ < 0) ? 1 : 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, NEXT, HOLD
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [7:0]                    r_motor;
  logic [7:0]                    r_latch_motor;
  logic                          r_latch_valid;
  logic [NUMBER_OF_MOTORS-1:0]   r_pid_update;
  logic                          r_spi_done_prev;
  logic [WD_W-1:0]               r_watchdog;
  logic [PERIOD_WIDTH-1:0]       r_period_timer;
  logic [PERIOD_WIDTH-1:0]       r_cycle_count;
  logic                          r_overrun;
  logic [15:0]                   r_timeout_count;
  logic [7:0]                    r_timeout_motor;

  logic                          w_done_edge;
  logic                          w_mask_any;
  logic [7:0]                    w_first_idx;
  logic [7:0]                    w_next_idx;
  logic                          w_next_found;
  logic [PERIOD_WIDTH-1:0]       w_period_last;
  logic                          w_hold_done;
  logic                          w_ovr_set;
  logic                          w_load_first;
  logic                          w_load_next;
  logic                          w_timer_clr;
  logic                          w_sweep_mark;
  logic                          w_timeout;
  logic [NUMBER_OF_MOTORS-1:0]   w_pid_nxt;

  assign w_done_edge   = spi_done & ~r_spi_done_prev;
  assign w_mask_any    = |motor_mask;
  assign w_period_last = period_cycles - PERIOD_WIDTH'(1);
  // period_cycles of 0 here means the mode was switched mid-sweep: release HOLD at once
  assign w_hold_done   = (period_cycles == '0) || (r_period_timer >= w_period_last);
  assign w_ovr_set     = (period_cycles != '0) && (r_period_timer >= w_period_last) &&
                         ((r_state == START) || (r_state == WAIT_DONE) || (r_state == NEXT));

  // Lowest set mask bit, and lowest set mask bit above the current motor
  always_comb begin
    w_first_idx  = '0;
    w_next_idx   = '0;
    w_next_found = 1'b0;
    for (int j = NUMBER_OF_MOTORS - 1; j >= 0; j--) begin
      if (motor_mask[j]) begin
        w_first_idx = 8'(j);
        if (8'(j) > r_motor) begin
          w_next_idx   = 8'(j);
          w_next_found = 1'b1;
        end
      end
    end
  end

  // Next-state and control strobes for the datapath
  always_comb begin
    w_state_nxt  = r_state;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    w_timer_clr  = 1'b0;
    w_sweep_mark = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_mask_any) begin
          w_state_nxt  = START;
          w_load_first = 1'b1;
          w_timer_clr  = 1'b1;
        end
      end
      START: w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (w_done_edge) begin
          w_state_nxt = NEXT;
        end else if (r_watchdog >= WD_LAST) begin
          w_state_nxt = NEXT;
          w_timeout   = 1'b1;
        end
      end
      NEXT: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_next_found) begin
          w_state_nxt = START;
          w_load_next = 1'b1;
        end else if (period_cycles == '0) begin
          if (w_mask_any) begin
            w_state_nxt  = START;
            w_load_first = 1'b1;
            w_sweep_mark = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!enable || !w_mask_any) begin
          w_state_nxt = IDLE;
        end else if (w_hold_done) begin
          w_state_nxt  = START;
          w_load_first = 1'b1;
          w_sweep_mark = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and done-edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_spi_done_prev <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_spi_done_prev <= spi_done;
    end
  end

  // Motor index, frame watchdog and sweep period timer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_motor        <= '0;
      r_watchdog     <= '0;
      r_period_timer <= '0;
      r_cycle_count  <= '0;
    end else begin
      if (w_load_first)      r_motor <= w_first_idx;
      else if (w_load_next)  r_motor <= w_next_idx;

      if (r_state == START)          r_watchdog <= '0;
      else if (r_state == WAIT_DONE) r_watchdog <= r_watchdog + 1'b1;

      if (w_timer_clr || w_sweep_mark)               r_period_timer <= '0;
      else if (r_state != IDLE && r_period_timer != '1) r_period_timer <= r_period_timer + 1'b1;

      if (w_sweep_mark)
        r_cycle_count <= (r_period_timer == '1) ? r_period_timer : r_period_timer + 1'b1;
    end
  end

  // Next PID pulse: one-hot of the slot latched in the previous cycle
  always_comb begin
    w_pid_nxt = '0;
    for (int j = 0; j < NUMBER_OF_MOTORS; j++)
      w_pid_nxt[j] = r_latch_valid && (r_latch_motor == 8'(j));
  end

  // Latch strobe one cycle after done edge, PID pulse one cycle after that
  always_ff @(posedge clock) begin
    if (reset) begin
      r_latch_valid <= 1'b0;
      r_latch_motor <= '0;
      r_pid_update  <= '0;
    end else begin
      r_latch_valid <= (r_state == WAIT_DONE) && w_done_edge;
      if ((r_state == WAIT_DONE) && w_done_edge) r_latch_motor <= r_motor;
      r_pid_update  <= w_pid_nxt;
    end
  end

  // Sticky status: a set or increment in the same cycle beats clear_status
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun       <= 1'b0;
      r_timeout_count <= '0;
      r_timeout_motor <= '0;
    end else begin
      if (w_ovr_set)         r_overrun <= 1'b1;
      else if (clear_status) r_overrun <= 1'b0;

      if (w_timeout) begin
        if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 1'b1;
        r_timeout_motor <= r_motor;
      end else if (clear_status) begin
        r_timeout_count <= '0;
      end
    end
  end

  // Route SpiControl's select only to the motor being serviced
  always_comb begin
    ss_n_o = '1;
    for (int j = 0; j < NUMBER_OF_MOTORS; j++)
      ss_n_o[j] = (busy && (r_motor == 8'(j))) ? ss_n : 1'b1;
  end

  assign spi_start     = (r_state == START);
  assign busy          = (r_state != IDLE);
  assign motor         = r_motor;
  assign latch_valid   = r_latch_valid;
  assign latch_motor   = r_latch_motor;
  assign pid_update    = r_pid_update;
  assign cycle_count   = r_cycle_count;
  assign overrun       = r_overrun;
  assign timeout_count = r_timeout_count;
  assign timeout_motor = r_timeout_motor;

endmodule

// File: tb/tb_myo_sweep_scheduler.sv
// tb_myo_sweep_scheduler: scoreboard bench. A small SPI responder raises done a
// fixed delay after each start, pushing the expected latch/PID events; a
// monitor pops and compares them, and also checks the expected motor order.
module tb_myo_sweep_scheduler;
  localparam int N    = 6;
  localparam int TMO  = 50;
  localparam int PW   = 32;
  localparam int DLY  = 41;          // cycles from the start cycle to the done edge
  localparam int FRM  = DLY + 2;     // START + wait + NEXT per serviced motor

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  motor_mask = '0;
  logic [PW-1:0] period_cycles = '0;
  logic          clear_status = 1'b0;
  logic          spi_done = 1'b0;
  logic          ss_n = 1'b1;
  logic          spi_start;
  logic [7:0]    motor;
  logic [N-1:0]  ss_n_o;
  logic          latch_valid;
  logic [7:0]    latch_motor;
  logic [N-1:0]  pid_update;
  logic [PW-1:0] cycle_count;
  logic          overrun;
  logic [15:0]   timeout_count;
  logic [7:0]    timeout_motor;
  logic          busy;

  myo_sweep_scheduler #(.NUMBER_OF_MOTORS(N), .CLOCK_SPEED_HZ(50_000_000),
                        .TIMEOUT_CYCLES(TMO), .PERIOD_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .motor_mask(motor_mask),
    .period_cycles(period_cycles), .clear_status(clear_status),
    .spi_done(spi_done), .ss_n(ss_n), .spi_start(spi_start), .motor(motor),
    .ss_n_o(ss_n_o), .latch_valid(latch_valid), .latch_motor(latch_motor),
    .pid_update(pid_update), .cycle_count(cycle_count), .overrun(overrun),
    .timeout_count(timeout_count), .timeout_motor(timeout_motor), .busy(busy));

  always #5 clock = ~clock;

  typedef struct { int m; int cyc; } exp_t;
  exp_t lq[$];
  exp_t pq[$];
  int   sq[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_starts = 0, n_m0 = 0, m0_last = 0, m0_prev = 0, n_latch = 0;
  int last_m = -1, last_cyc = 0, gap23 = 0;
  int done_cnt = 0, hi_cnt = 0, cur_m = 0, dead_motor = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_sweeps(input logic [N-1:0] mk, input int n);
    for (int s = 0; s < n; s++)
      for (int j = 0; j < N; j++)
        if (mk[j]) sq.push_back(j);
  endfunction

  // Monitor + SPI responder, on the falling edge
  always @(negedge clock) begin
    exp_t e;
    logic [N-1:0] oh;
    cyc++;
    if (reset) begin
      done_cnt = 0; hi_cnt = 0; spi_done = 1'b0; ss_n = 1'b1;
    end else begin
      if (latch_valid) begin
        n_latch++;
        if (lq.size() == 0) chk("latch_unexpected", latch_motor, 8'hFF);
        else begin
          e = lq.pop_front();
          chk("latch_motor", latch_motor, e.m);
          chk("latch_cycle", cyc, e.cyc);
        end
      end
      if (pid_update != '0) begin
        if (pq.size() == 0) chk("pid_unexpected", pid_update, 0);
        else begin
          e = pq.pop_front();
          oh = '0; oh[e.m] = 1'b1;
          chk("pid_onehot", pid_update, oh);
          chk("pid_cycle", cyc, e.cyc);
        end
      end
      if (hi_cnt > 0) begin
        hi_cnt--;
        if (hi_cnt == 0) spi_done = 1'b0;
      end
      if (spi_start) begin
        n_starts++;
        if (sq.size() != 0) begin
          cur_m = sq.pop_front();
          chk("start_motor", motor, cur_m);
        end else cur_m = motor;
        if (cur_m == 0) begin m0_prev = m0_last; m0_last = cyc; n_m0++; end
        if (cur_m == 3 && last_m == 2) gap23 = cyc - last_cyc;
        last_m = cur_m; last_cyc = cyc;
        ss_n = 1'b0;
        done_cnt = (cur_m == dead_motor) ? 0 : DLY;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          spi_done = 1'b1; ss_n = 1'b1; hi_cnt = 2;
          lq.push_back('{m: cur_m, cyc: cyc + 1});
          pq.push_back('{m: cur_m, cyc: cyc + 2});
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic do_reset();
    enable = 1'b0; clear_status = 1'b0; reset = 1'b1;
    tick(2);
    reset = 1'b0;
    lq.delete(); pq.delete(); sq.delete();
    n_starts = 0; n_m0 = 0; n_latch = 0; last_m = -1; gap23 = 0; dead_motor = -1;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_starts < n && k < budget) begin tick(); k++; end
    chk("start_wait", n_starts >= n, 1);
  endtask

  task automatic wait_m0(input int n, input int budget);
    int k = 0;
    while (n_m0 < n && k < budget) begin tick(); k++; end
    chk("m0_wait", n_m0 >= n, 1);
  endtask

  task automatic stop_and_drain(input string tag);
    int k = 0;
    enable = 1'b0;
    while (busy && k < 400) begin tick(); k++; end
    chk({tag, "_idle"}, busy, 0);
    tick(4);
    chk({tag, "_latch_q"}, lq.size(), 0);
    chk({tag, "_pid_q"}, pq.size(), 0);
    sq.delete();
  endtask

  initial begin
    int snap;
    // Reset values
    do_reset();
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_motor", motor, 0);
    chk("rst_ssn", ss_n_o, {N{1'b1}});
    chk("rst_latch", {latch_valid, latch_motor}, 0);
    chk("rst_pid", pid_update, 0);
    chk("rst_status", {cycle_count, overrun, timeout_count, timeout_motor}, 0);

    // Free-run, sparse mask: 0,2,3,5,...
    do_reset();
    motor_mask = 6'b101101; period_cycles = 0;
    push_sweeps(6'b101101, 4);
    enable = 1'b1;
    wait_starts(2, 200);
    tick(5);
    chk("fr_ssn_frame", ss_n_o, 6'b111011);
    wait_starts(9, 600);
    chk("fr_cycle_count", cycle_count, 4 * FRM);
    chk("fr_overrun", overrun, 0);
    stop_and_drain("fr");

    // Period mode
    do_reset();
    motor_mask = 6'b101101; period_cycles = 1000;
    push_sweeps(6'b101101, 4);
    enable = 1'b1;
    wait_m0(3, 3000);
    chk("per_spacing", m0_last - m0_prev, 1000);
    chk("per_cycle_count", cycle_count, 1000);
    chk("per_overrun", overrun, 0);
    stop_and_drain("per");

    // Overrun: 4 motors do not fit in 100 clocks
    do_reset();
    motor_mask = 6'b001111; period_cycles = 100;
    push_sweeps(6'b001111, 4);
    enable = 1'b1;
    wait_m0(2, 600);
    chk("ovr_spacing", m0_last - m0_prev, 4 * FRM + 1);
    chk("ovr_cycle_count", cycle_count, 4 * FRM + 1);
    chk("ovr_flag", overrun, 1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("ovr_cleared", overrun, 0);
    stop_and_drain("ovr");

    // Watchdog timeout on motor 2
    do_reset();
    motor_mask = 6'b001111; period_cycles = 0; dead_motor = 2;
    push_sweeps(6'b001111, 4);
    enable = 1'b1;
    wait_starts(9, 800);
    chk("tmo_gap", gap23, TMO + 2);
    chk("tmo_count", timeout_count, 2);
    chk("tmo_motor", timeout_motor, 2);
    chk("tmo_cycle_count", cycle_count, 3 * FRM + TMO + 2);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("tmo_cleared", timeout_count, 0);
    stop_and_drain("tmo");

    // Enable dropped during motor 1's frame
    do_reset();
    motor_mask = 6'b001111; period_cycles = 0;
    push_sweeps(6'b001111, 2);
    enable = 1'b1;
    wait_starts(2, 200);
    tick(3);
    stop_and_drain("en");
    chk("en_ssn", ss_n_o, {N{1'b1}});
    chk("en_motor_held", motor, 1);
    chk("en_latches", n_latch, 2);
    snap = n_starts;
    tick(100);
    chk("en_no_start", n_starts, snap);

    // Reset in WAIT_DONE, then mask=0 keeps it idle
    do_reset();
    motor_mask = 6'b001111; period_cycles = 0;
    push_sweeps(6'b001111, 1);
    enable = 1'b1;
    wait_starts(1, 50);
    tick(5);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", spi_start, 0);
    chk("mid_rst_ssn", ss_n_o, {N{1'b1}});
    chk("mid_rst_outs", {motor, latch_valid, pid_update}, 0);
    motor_mask = '0; sq.delete();
    reset = 1'b0;
    snap = n_starts;
    tick(100);
    chk("mask0_no_start", n_starts, snap);
    chk("mask0_idle", busy, 0);
    chk("mask0_no_latch", lq.size() + pq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1, "bench timed out");
  end
endmodule
